// File: rtl/rx_deser_pkg.sv
// Shared definitions for the rx_deser serial frame receiver: FSM encoding,
// default frame geometry and bit-counter width.
package rx_deser_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int STOP_BITS_DEF = 2;
  // Start bit + data bits + stop bits for the default geometry.
  localparam int FRAME_LEN     = 1 + DATA_BITS_DEF + STOP_BITS_DEF;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP1 = 2'd2,
    ST_STOP2 = 2'd3
  } state_t;

endpackage

// File: rtl/rx_deser_if.sv
// Receiver-side bundle: serial input, consumer handshake and status outputs.
interface rx_deser_if
  import rx_deser_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic                 rx_in;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun;
  logic [1:0]           state_out;

  // Line driver / consumer side.
  modport master (
    output rx_in, rd_ack,
    input  data_out, data_valid, frame_err, overrun, state_out
  );

  // Receiver side.
  modport slave (
    input  rx_in, rd_ack,
    output data_out, data_valid, frame_err, overrun, state_out
  );

endinterface

// File: rtl/rx_deser_shreg.sv
// Serial-in/parallel-out shift register, LSB first: each enabled shift moves
// the word right and inserts the new bit at the MSB, so after WIDTH shifts the
// first bit received sits in bit 0.
module rx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rx_deser.sv
// Serial frame deserializer: one bit per clock, start bit 1, LSB-first data,
// fixed-length stop bits. Delivers good bytes through a valid/ack holding
// register, flags bad stop bits and dropped frames.
module rx_deser
  import rx_deser_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  rx_deser_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic                 stop1_ok_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 frame_done;
  logic                 stop_good;

  rx_shreg #(.WIDTH(DATA_BITS)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .en    (state_q == ST_DATA),
    .din   (bus.rx_in),
    .q     (shreg_q)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and frame-completion decode.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths the case statement does not cover.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    stop_good  = bus.rx_in & ((STOP_BITS == 1) | stop1_ok_q);
    unique case (state_q)
      ST_IDLE:  if (bus.rx_in) state_d = ST_DATA;
      ST_DATA:  if (count_q == LAST_BIT) state_d = ST_STOP1;
      ST_STOP1: begin
        if (STOP_BITS > 1) begin
          state_d = ST_STOP2;
        end else begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      ST_STOP2: begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Data-bit counter and first stop-bit capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      stop1_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:  count_q <= '0;
        ST_DATA:  count_q <= (count_q == LAST_BIT) ? '0 : count_q + 4'd1;
        ST_STOP1: stop1_ok_q <= bus.rx_in;
        default:  ;
      endcase
    end
  end

  // Holding register, valid/ack handshake, error pulse and sticky overrun.
  // A completing frame takes precedence over a plain acknowledge; an ack on
  // the completion edge of a good frame lets the new byte replace the old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (frame_done) begin
        if (!stop_good) begin
          ferr_q <= 1'b1;
        end else if (!valid_q || bus.rd_ack) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.rd_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_rx_deser.sv
// Directed bench for rx_deser: inputs change 1 ns after a rising edge and
// outputs are checked at the same point, i.e. after the edge settled.
module tb_rx_deser;
  import rx_deser_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  rx_deser_if #(.DATA_BITS(8)) bus ();

  rx_deser #(.DATA_BITS(8), .STOP_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full frame; leaves rx_in idle (0) after the last stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2,
                            input logic ack_last);
    bus.rx_in = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      tick();
    end
    bus.rx_in = s1;
    tick();
    bus.rx_in  = s2;
    bus.rd_ack = ack_last;
    tick();
    bus.rd_ack = 1'b0;
    bus.rx_in  = 1'b0;
  endtask

  task automatic ack_cycle();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d exp 0", bus.state_out); end
    tests_run++; if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h exp 00", bus.data_out); end
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b exp 0", bus.frame_err); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b exp 0", bus.overrun); end
  endtask

  task automatic test_basic();
    logic       vec [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_st [11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.rx_in = 1'b0;
    tick(); tick();
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL idle_hold: got %0d exp 0", bus.state_out); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      bus.rx_in = vec[i];
      tick();
      tests_run++; if (bus.state_out !== exp_st[i]) begin tests_failed++; $display("FAIL basic_state[%0d]: got %0d exp %0d", i, bus.state_out, exp_st[i]); end
    end
    bus.rx_in = 1'b0;
    tests_run++; if (bus.data_out !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h exp a5", bus.data_out); end
    tests_run++; if (bus.data_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b exp 1", bus.data_valid); end
    tests_run++; if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL basic_ferr: got %b exp 0", bus.frame_err); end
    ack_cycle();
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_ack: got %b exp 0", bus.data_valid); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    tests_run++; if (bus.frame_err !== 1'b1) begin tests_failed++; $display("FAIL ferr_pulse: got %b exp 1", bus.frame_err); end
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL ferr_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.data_out !== 8'hA5) begin tests_failed++; $display("FAIL ferr_data: got %h exp a5", bus.data_out); end
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL ferr_state: got %0d exp 0", bus.state_out); end
    tick();
    tests_run++; if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL ferr_one_cycle: got %b exp 0", bus.frame_err); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bus.data_out !== 8'h11) begin tests_failed++; $display("FAIL ovr_first: got %h exp 11", bus.data_out); end
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bus.data_out !== 8'h11) begin tests_failed++; $display("FAIL ovr_kept: got %h exp 11", bus.data_out); end
    tests_run++; if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b exp 1", bus.overrun); end
    tests_run++; if (bus.data_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %b exp 1", bus.data_valid); end
    ack_cycle();
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_ack_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_ack_clr: got %b exp 0", bus.overrun); end
    ack_cycle();
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_ack_valid: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.data_out !== 8'h11) begin tests_failed++; $display("FAIL idle_ack_data: got %h exp 11", bus.data_out); end
  endtask

  task automatic test_ack_on_complete();
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    tests_run++; if (bus.data_out !== 8'h22) begin tests_failed++; $display("FAIL ackc_data: got %h exp 22", bus.data_out); end
    tests_run++; if (bus.data_valid !== 1'b1) begin tests_failed++; $display("FAIL ackc_valid: got %b exp 1", bus.data_valid); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL ackc_ovr: got %b exp 0", bus.overrun); end
    ack_cycle();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) begin
      bus.rx_in = 1'b1;
      tick();
    end
    tests_run++; if (bus.state_out !== 2'd1) begin tests_failed++; $display("FAIL rstm_pre: got %0d exp 1", bus.state_out); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL rstm_async: got %0d exp 0", bus.state_out); end
    tests_run++; if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL rstm_data: got %h exp 00", bus.data_out); end
    bus.rx_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL rstm_idle: got %0d exp 0", bus.state_out); end
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL rstm_valid: got %b exp 0", bus.data_valid); end
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bus.data_out !== 8'h5A) begin tests_failed++; $display("FAIL rstm_5a: got %h exp 5a", bus.data_out); end
    tests_run++; if (bus.data_valid !== 1'b1) begin tests_failed++; $display("FAIL rstm_5a_valid: got %b exp 1", bus.data_valid); end
    tests_run++; if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL rstm_ferr: got %b exp 0", bus.frame_err); end
    ack_cycle();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    tests_run++; if (bus.data_out !== 8'h01) begin tests_failed++; $display("FAIL b2b_first: got %h exp 01", bus.data_out); end
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL b2b_mid_state: got %0d exp 0", bus.state_out); end
    send_frame(8'h80, 1'b1, 1'b1, 1'b1);
    tests_run++; if (bus.data_out !== 8'h80) begin tests_failed++; $display("FAIL b2b_second: got %h exp 80", bus.data_out); end
    tests_run++; if (bus.data_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid: got %b exp 1", bus.data_valid); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovr: got %b exp 0", bus.overrun); end
    tests_run++; if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_ferr: got %b exp 0", bus.frame_err); end
    ack_cycle();
    tests_run++; if (bus.data_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_ack: got %b exp 0", bus.data_valid); end
    tests_run++; if (bus.state_out !== 2'd0) begin tests_failed++; $display("FAIL b2b_end_state: got %0d exp 0", bus.state_out); end
  endtask

  initial begin
    bus.rx_in  = 1'b0;
    bus.rd_ack = 1'b0;
    rst_n      = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_frame_err();
    test_overrun();
    test_ack_on_complete();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_deser.md
RX_DESER -- requirements
Module: rx_deser

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter STOP_BITS, default 2, number of stop bits per frame (fixed length, always checked).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock; one serial bit per clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rx_in  input  1  serial line: idle 0, start bit 1, DATA_BITS data bits LSB first, STOP_BITS stop bits 1.
REQ-007 rd_ack  input  1  consumer accepts data_out this cycle (honoured only while data_valid=1).
REQ-008 data_out  output  DATA_BITS  last good received byte, held stable while data_valid=1.
REQ-009 data_valid  output  1  data_out holds an unconsumed byte.
REQ-010 frame_err  output  1  one-cycle pulse: completed frame had a stop bit of 0.
REQ-011 overrun  output  1  sticky: a good frame was dropped because data_valid was still 1.
REQ-012 state_out  output  2  current state encoding, for debug/bench.

Function
REQ-013 SHALL be a Moore FSM with states IDLE=2'd0, DATA=2'd1, STOP1=2'd2, STOP2=2'd3; all outputs registered.
REQ-014 IDLE: rx_in=1 sampled at edge -> DATA, bit counter cleared to 0; rx_in=0 -> stay IDLE.
REQ-015 DATA: each edge shifts rx_in into bit position count (LSB first) and increments count; after DATA_BITS samples -> STOP1.
REQ-016 Bit counter SHALL be 4 bits wide and never index beyond DATA_BITS-1.
REQ-017 STOP1: sample rx_in as stop bit 1 -> STOP2; STOP2: sample stop bit 2 -> IDLE (no early abort on bad stop bit).
REQ-018 Start-bit sample at edge N: data bits sampled at edges N+1..N+8, stop bits at N+9, N+10; results visible after edge N+10.
REQ-019 Good frame (both stop bits 1) and data_valid=0: load data_out, set data_valid at edge N+10.
REQ-020 Good frame, data_valid=1, rd_ack=0 at edge N+10: drop new byte, keep data_out, set overrun.
REQ-021 Good frame, data_valid=1, rd_ack=1 at edge N+10: load new byte, data_valid stays 1, overrun unchanged.
REQ-022 Bad frame (either stop bit 0): frame_err=1 for exactly the cycle after edge N+10; data_out, data_valid unchanged.
REQ-023 rd_ack=1 with data_valid=1 and no frame completing: clear data_valid and overrun at that edge.
REQ-024 rd_ack while data_valid=0: ignored.
REQ-025 Back-to-back frames: rx_in=1 in IDLE cycle immediately after STOP2 SHALL start a new frame with no gap.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, count 0, shift register 0, data_out 0, data_valid 0, frame_err 0, overrun 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new start bit.

Structure
REQ-028 State encodings, DATA_BITS/STOP_BITS defaults and frame length constant (11) SHALL live in the shared package.
REQ-029 One sub-module is natural: rx_shreg (DATA_BITS serial-in/parallel-out shift register with clear and enable).

Verification
REQ-030 Idle 0, then 1,1,0,1,0,0,1,0,1,1,1 -> data_out=8'hA5, data_valid=1 after 11th edge; frame_err=0.
REQ-031 Frame 8'h3C with stop1=0 -> frame_err one-cycle pulse, data_valid stays 0, FSM back in IDLE.
REQ-032 Frame 8'h11 accepted, no rd_ack, frame 8'h22 -> data_out=8'h11, overrun=1; rd_ack -> data_valid=0, overrun=0.
REQ-033 Frame 8'h11 valid, rd_ack=1 on completion edge of 8'h22 -> data_out=8'h22, data_valid=1, overrun=0.
REQ-034 rst_n pulsed low at bit 4 of 8'hFF frame, then clean 8'h5A frame -> only 8'h5A delivered, no frame_err.
REQ-035 Two frames 8'h01, 8'h80 with no idle gap, acking each -> both delivered in order, state_out returns to 2'd0.
